// File: rtl/regbank_arbiter.sv
// Two-requester round-robin front end for a single-port register bank.
// Optional feature macro: REGARB_ZERO_REG_EN (address 0 reads as zero and ignores writes).
module regbank_arbiter #(
    parameter int DATA_WIDTH = 31,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic                  a_lock,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic                  b_lock,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_data,
    output logic [DATA_WIDTH-1:0] bank_data,
    output logic [ADDR_WIDTH-1:0] bank_write_addr,
    output logic [ADDR_WIDTH-1:0] bank_read_addr,
    output logic                  bank_we,
    input  logic [DATA_WIDTH-1:0] bank_q,
    output logic                  init_done
);

`ifdef REGARB_ZERO_REG_EN
    localparam logic ZERO_REG_EN = 1'b1;
`else
    localparam logic ZERO_REG_EN = 1'b0;
`endif

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_ARB    = 2'd1,
        ST_LOCK_A = 2'd2,
        ST_LOCK_B = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    last_grant_q, last_grant_d;   // 1 = B was last granted
    logic                    init_done_q, init_done_d;
    logic                    a_rsp_valid_q, a_rsp_valid_d;
    logic                    b_rsp_valid_q, b_rsp_valid_d;
    logic                    rsp_zero_q, rsp_zero_d;

    logic                    a_ready_s, b_ready_s, xfer_s;
    logic                    x_we_s, x_lock_s;
    logic [ADDR_WIDTH-1:0]   x_addr_s;
    logic [DATA_WIDTH-1:0]   x_wdata_s;
    logic                    bank_we_s;
    logic [ADDR_WIDTH-1:0]   bank_write_addr_s, bank_read_addr_s;
    logic [DATA_WIDTH-1:0]   bank_data_s;

    // Grant selection, bank drive and next-state computation.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        last_grant_d      = last_grant_q;
        init_done_d       = init_done_q;
        a_rsp_valid_d     = 1'b0;
        b_rsp_valid_d     = 1'b0;
        rsp_zero_d        = 1'b0;
        a_ready_s         = 1'b0;
        b_ready_s         = 1'b0;
        bank_we_s         = 1'b0;
        bank_write_addr_s = ADDR_ZERO;
        bank_read_addr_s  = ADDR_ZERO;
        bank_data_s       = {DATA_WIDTH{1'b0}};

        case (state_q)
            ST_INIT: begin
                bank_we_s         = 1'b1;
                bank_write_addr_s = cnt_q;
                cnt_d             = cnt_q + ADDR_ONE;
                if (cnt_q == ADDR_LAST) begin
                    state_d     = ST_ARB;
                    init_done_d = 1'b1;
                end else begin
                    init_done_d = init_done_q;
                end
            end
            ST_ARB: begin
                a_ready_s = a_valid & (~b_valid | last_grant_q);
                b_ready_s = b_valid & (~a_valid | ~last_grant_q);
            end
            ST_LOCK_A: a_ready_s = a_valid;
            ST_LOCK_B: b_ready_s = b_valid;
            default:   state_d   = ST_INIT;
        endcase

        xfer_s    = a_ready_s | b_ready_s;
        x_we_s    = b_ready_s ? b_we    : a_we;
        x_lock_s  = b_ready_s ? b_lock  : a_lock;
        x_addr_s  = b_ready_s ? b_addr  : a_addr;
        x_wdata_s = b_ready_s ? b_wdata : a_wdata;

        if (xfer_s) begin
            last_grant_d = b_ready_s;
            if (x_we_s) begin
                // With the zero register, writes to address 0 handshake but never reach the bank.
                bank_we_s         = ~(ZERO_REG_EN & (x_addr_s == ADDR_ZERO));
                bank_write_addr_s = x_addr_s;
                bank_data_s       = x_wdata_s;
            end else begin
                bank_read_addr_s = x_addr_s;
                a_rsp_valid_d    = a_ready_s;
                b_rsp_valid_d    = b_ready_s;
                rsp_zero_d       = ZERO_REG_EN & (x_addr_s == ADDR_ZERO);
            end
            if (x_lock_s) begin
                state_d = b_ready_s ? ST_LOCK_B : ST_LOCK_A;
            end else begin
                state_d = ST_ARB;
            end
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // State, init counter, arbitration history and response flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            cnt_q         <= ADDR_ZERO;
            last_grant_q  <= 1'b1;
            init_done_q   <= 1'b0;
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            rsp_zero_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            init_done_q   <= init_done_d;
            a_rsp_valid_q <= a_rsp_valid_d;
            b_rsp_valid_q <= b_rsp_valid_d;
            rsp_zero_q    <= rsp_zero_d;
        end
    end

    assign a_ready         = a_ready_s;
    assign b_ready         = b_ready_s;
    assign bank_we         = bank_we_s & rst_n;
    assign bank_write_addr = bank_write_addr_s;
    assign bank_read_addr  = bank_read_addr_s;
    assign bank_data       = bank_data_s;
    assign init_done       = init_done_q;
    assign a_rsp_valid     = a_rsp_valid_q;
    assign b_rsp_valid     = b_rsp_valid_q;
    assign a_rsp_data      = (a_rsp_valid_q & ~rsp_zero_q) ? bank_q : {DATA_WIDTH{1'b0}};
    assign b_rsp_data      = (b_rsp_valid_q & ~rsp_zero_q) ? bank_q : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed self-checking bench for regbank_arbiter with a behavioural register bank.
module tb_regbank_arbiter;
    localparam int DW = 31;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid, a_we, a_lock, b_valid, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid;
    logic [DW-1:0] a_rsp_data, b_rsp_data;
    logic [DW-1:0] bank_data, bank_q;
    logic [AW-1:0] bank_write_addr, bank_read_addr;
    logic          bank_we, init_done;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bank_we) mem[bank_write_addr] <= bank_data;
        bank_q <= mem[bank_read_addr];
    end

    regbank_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_lock(a_lock),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_lock(b_lock),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
        .bank_data(bank_data), .bank_write_addr(bank_write_addr), .bank_read_addr(bank_read_addr),
        .bank_we(bank_we), .bank_q(bank_q), .init_done(init_done)
    );

    task automatic drive_idle();
        a_valid = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        a_valid = 1'b1; b_valid = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bank_we !== 1'b0) begin errors++; $display("FAIL rst_bank_we: got %b exp 0", bank_we); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b exp 0", init_done); end
        checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b%b exp 00", a_ready, b_ready); end
        checks++; if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b%b exp 00", a_rsp_valid, b_rsp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_init();
        for (int i = 0; i < 32; i++) begin
            #1;
            checks++;
            if (bank_we !== 1'b1 || bank_write_addr !== i[AW-1:0] || bank_data !== '0) begin
                errors++; $display("FAIL init_write[%0d]: got we=%b addr=%0d data=%h exp we=1 addr=%0d data=0", i, bank_we, bank_write_addr, bank_data, i);
            end
            checks++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0 || init_done !== 1'b0) begin
                errors++; $display("FAIL init_busy[%0d]: got a_ready=%b b_ready=%b init_done=%b exp 0 0 0", i, a_ready, b_ready, init_done);
            end
            @(negedge clk);
        end
        drive_idle();
        #1;
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done: got %b exp 1", init_done); end
        checks++; if (bank_we !== 1'b0 || bank_write_addr !== '0 || bank_read_addr !== '0) begin errors++; $display("FAIL idle_bus: got we=%b wa=%0d ra=%0d exp 0 0 0", bank_we, bank_write_addr, bank_read_addr); end
    endtask

    task automatic test_write_read();
        a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd5; a_wdata = 31'h1234;
        #1;
        checks++; if (a_ready !== 1'b1 || bank_we !== 1'b1 || bank_write_addr !== 5'd5 || bank_data !== 31'h1234) begin
            errors++; $display("FAIL wr_handshake: got rdy=%b we=%b wa=%0d d=%h exp 1 1 5 1234", a_ready, bank_we, bank_write_addr, bank_data); end
        @(negedge clk);
        a_we = 1'b0;
        #1;
        checks++; if (a_ready !== 1'b1 || bank_we !== 1'b0 || bank_read_addr !== 5'd5) begin
            errors++; $display("FAIL rd_handshake: got rdy=%b we=%b ra=%0d exp 1 0 5", a_ready, bank_we, bank_read_addr); end
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        checks++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 31'h1234) begin
            errors++; $display("FAIL rd_after_wr: got v=%b d=%h exp 1 1234", a_rsp_valid, a_rsp_data); end
        checks++; if (b_rsp_valid !== 1'b0 || b_rsp_data !== '0) begin
            errors++; $display("FAIL b_rsp_quiet: got v=%b d=%h exp 0 0", b_rsp_valid, b_rsp_data); end
        @(negedge clk);
        #1;
        checks++; if (a_rsp_valid !== 1'b0 || a_rsp_data !== '0) begin
            errors++; $display("FAIL rsp_one_cycle: got v=%b d=%h exp 0 0", a_rsp_valid, a_rsp_data); end
    endtask

    task automatic test_round_robin();
        logic exp_a;
        b_valid = 1'b1; b_we = 1'b1; b_addr = 5'd6; b_wdata = 31'h0abc;
        #1;
        checks++; if (b_ready !== 1'b1 || bank_we !== 1'b1 || bank_write_addr !== 5'd6) begin
            errors++; $display("FAIL b_write: got rdy=%b we=%b wa=%0d exp 1 1 6", b_ready, bank_we, bank_write_addr); end
        @(negedge clk);
        b_we = 1'b0;
        a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd5;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            #1;
            checks++; if (a_ready !== exp_a || b_ready !== ~exp_a || bank_read_addr !== (exp_a ? 5'd5 : 5'd6)) begin
                errors++; $display("FAIL rr_grant[%0d]: got a=%b b=%b ra=%0d exp a=%b", i, a_ready, b_ready, bank_read_addr, exp_a); end
            checks++; if (a_rsp_valid !== (i % 2 == 1) || b_rsp_valid !== (i > 0 && i % 2 == 0)) begin
                errors++; $display("FAIL rr_rsp_valid[%0d]: got a=%b b=%b", i, a_rsp_valid, b_rsp_valid); end
            if (i > 0) begin
                checks++; if ((exp_a ? b_rsp_data : a_rsp_data) !== (exp_a ? 31'h0abc : 31'h1234)) begin
                    errors++; $display("FAIL rr_rsp_data[%0d]: got a=%h b=%h", i, a_rsp_data, b_rsp_data); end
            end
            @(negedge clk);
        end
        drive_idle();
        #1;
        checks++; if (b_rsp_valid !== 1'b1 || b_rsp_data !== 31'h0abc || a_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rr_last_rsp: got bv=%b bd=%h av=%b exp 1 abc 0", b_rsp_valid, b_rsp_data, a_rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_lock();
        logic [2:0] lock_v = 3'b011;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd11;
        for (int k = 0; k < 3; k++) begin
            a_valid = 1'b1; a_we = 1'b1; a_lock = lock_v[k];
            a_addr = 5'd10 + k[AW-1:0]; a_wdata = 31'h100 + k[DW-1:0];
            #1;
            checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0 || bank_we !== 1'b1 || bank_write_addr !== a_addr) begin
                errors++; $display("FAIL lock_write[%0d]: got a=%b b=%b we=%b wa=%0d", k, a_ready, b_ready, bank_we, bank_write_addr); end
            @(negedge clk);
            if (k == 1) begin
                a_valid = 1'b0;
                #1;
                checks++; if (b_ready !== 1'b0 || a_ready !== 1'b0) begin
                    errors++; $display("FAIL lock_hold_idle: got a=%b b=%b exp 0 0", a_ready, b_ready); end
                @(negedge clk);
            end
        end
        a_valid = 1'b0; a_lock = 1'b0;
        #1;
        checks++; if (b_ready !== 1'b1 || bank_read_addr !== 5'd11) begin
            errors++; $display("FAIL lock_release: got b=%b ra=%0d exp 1 11", b_ready, bank_read_addr); end
        @(negedge clk);
        b_valid = 1'b0;
        #1;
        checks++; if (b_rsp_valid !== 1'b1 || b_rsp_data !== 31'h101) begin
            errors++; $display("FAIL lock_data: got v=%b d=%h exp 1 101", b_rsp_valid, b_rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1; a_we = 1'b0; a_lock = 1'b1; a_addr = 5'd10;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL mid_handshake: got %b exp 1", a_ready); end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        checks++; if (a_rsp_valid !== 1'b0 || a_rsp_data !== '0 || init_done !== 1'b0 || bank_we !== 1'b0) begin
            errors++; $display("FAIL mid_reset_clear: got v=%b d=%h done=%b we=%b exp 0 0 0 0", a_rsp_valid, a_rsp_data, init_done, bank_we); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (32) @(negedge clk);
        #1;
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL reinit_done: got %b exp 1", init_done); end
        b_valid = 1'b1; b_addr = 5'd10;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL lock_cleared: got b_ready=%b exp 1", b_ready); end
        @(negedge clk);
        b_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd5;
        #1;
        checks++; if (b_rsp_valid !== 1'b1 || b_rsp_data !== '0) begin
            errors++; $display("FAIL reinit_addr10: got v=%b d=%h exp 1 0", b_rsp_valid, b_rsp_data); end
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        checks++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== '0) begin
            errors++; $display("FAIL reinit_addr5: got v=%b d=%h exp 1 0", a_rsp_valid, a_rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_zero_reg();
`ifdef REGARB_ZERO_REG_EN
        logic          exp_we = 1'b0;
        logic [DW-1:0] exp_d  = 31'h0;
`else
        logic          exp_we = 1'b1;
        logic [DW-1:0] exp_d  = 31'h7;
`endif
        a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd0; a_wdata = 31'h7;
        #1;
        checks++; if (a_ready !== 1'b1 || bank_we !== exp_we) begin
            errors++; $display("FAIL zero_write: got rdy=%b we=%b exp 1 %b", a_ready, bank_we, exp_we); end
        @(negedge clk);
        a_we = 1'b0;
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        checks++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== exp_d) begin
            errors++; $display("FAIL zero_read: got v=%b d=%h exp 1 %h", a_rsp_valid, a_rsp_data, exp_d); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_round_robin();
        test_lock();
        test_reset_mid();
        test_zero_reg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
